conv_window_ctrl: RTL

Frame sequencer for the shift-register line-buffer / sliding-window datapath of the convolution engine. It tracks the row and column position of every accepted pixel in a raster-scan frame and asserts `win_valid` exactly on the cycles where the K×K window formed by the line buffers is fully inside the image and aligned to the stride. It also reports the output-map coordinate and a frame-done pulse. It sits beside the line buffers and drives the downstream MAC array's input-valid.

---
 rtl/conv_window_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/conv_window_ctrl.sv
// Raster-scan frame sequencer for the line-buffer window: flags stride-aligned full KxK windows and output-map coordinates.
// One cycle from a sampled valid_in to win_valid/out_row/out_col; no backpressure, counters advance only on valid_in.
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 220,
    parameter int IMAGE_HEIGHT = 220,
    parameter int KERNEL       = 3,
    parameter int STRIDE       = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 valid_in,
    output logic                 busy,
    output logic                 win_valid,
    output logic [CNT_WIDTH-1:0] out_row,
    output logic [CNT_WIDTH-1:0] out_col,
    output logic                 frame_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_COL  = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW  = CNT_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] KM1       = CNT_WIDTH'(KERNEL - 1);
    localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'((KERNEL > 1) ? KERNEL - 2 : 0);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [2:0]           PH_LAST   = 3'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t               state, next_state;
    logic [CNT_WIDTH-1:0] row, col, orow, ocol;
    logic [2:0]           row_ph, col_ph;
    logic                 accept, wrap, last_pix, issue;

    assign accept   = valid_in && (state == FILL || state == RUN);
    assign wrap     = accept && (col == LAST_COL);
    assign last_pix = (state == RUN) && wrap && (row == LAST_ROW);
    assign issue    = (state == RUN) && valid_in && (row >= KM1) && (col >= KM1)
                      && (row_ph == 3'd0) && (col_ph == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (KERNEL == 1) ? RUN : FILL;
            FILL: if (wrap && row == FILL_LAST) next_state = RUN;
            RUN:  if (last_pix) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row        <= '0;
            col        <= '0;
            orow       <= '0;
            ocol       <= '0;
            row_ph     <= '0;
            col_ph     <= '0;
            win_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= issue;
            busy       <= (next_state != IDLE);
            frame_done <= (next_state == DONE);
            if (issue) begin
                out_row <= orow;
                out_col <= ocol;
            end
            // Counters are cleared on the final pixel so the next frame starts from the origin.
            if (state == IDLE || state == DONE || last_pix) begin
                row    <= '0;
                col    <= '0;
                orow   <= '0;
                ocol   <= '0;
                row_ph <= '0;
                col_ph <= '0;
            end else if (accept) begin
                if (wrap) begin
                    col    <= '0;
                    col_ph <= '0;
                    ocol   <= '0;
                    row    <= row + ONE;
                    if (row >= KM1) begin
                        row_ph <= (row_ph == PH_LAST) ? 3'd0 : row_ph + 3'd1;
                        if (row_ph == 3'd0) orow <= orow + ONE;
                    end
                end else begin
                    col <= col + ONE;
                    if (col >= KM1) col_ph <= (col_ph == PH_LAST) ? 3'd0 : col_ph + 3'd1;
                    if (issue) ocol <= ocol + ONE;
                end
            end
        end
    end

endmodule
